// File: rtl/limbus_sys_cpu_oci_dct_packer.sv
// limbus_sys_cpu_oci_dct_packer
//
// Packs 2-bit direct-branch trace codes into a 30-bit buffer, LSB-first with
// the newest code in bits [1:0]. The buffer is emitted as a 34-bit packet
// {count, buffer} when it fills, on a flush request, or when tracing stops.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset_n    : asynchronous active-low reset
//   trc_on     : trace enable; codes are accepted only while high
//   dct_valid  : a code is present on dct_code this cycle
//   dct_code   : 2-bit direct-branch code
//   flush      : single-cycle request to emit a partial buffer
//   ovf_clr    : clears the sticky overflow flag
//   pkt_ready  : downstream accepts pkt_data this cycle
//   dct_buffer : live packed codes
//   dct_count  : number of valid codes in dct_buffer
//   pkt_valid  : pkt_data holds an unconsumed packet
//   pkt_data   : packet {count[3:0], buffer[29:0]}
//   overflow   : sticky, at least one code was dropped
//   fsm_state  : packer state (0 IDLE, 1 COLLECT, 2 PEND)
//
// Handshake: a packet transfers on any edge where pkt_valid and pkt_ready are
// both high. While pkt_valid is high and pkt_ready is low, pkt_data is held
// stable; pkt_valid never drops without a transfer.
module limbus_sys_cpu_oci_dct_packer #(
    parameter int FULL_COUNT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trc_on,
    input  logic        dct_valid,
    input  logic [1:0]  dct_code,
    input  logic        flush,
    input  logic        ovf_clr,
    input  logic        pkt_ready,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        pkt_valid,
    output logic [33:0] pkt_data,
    output logic        overflow,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PEND    = 2'd2
    } state_t;

    localparam logic [3:0] FULL = 4'(FULL_COUNT);

    state_t      state, state_n;
    logic [29:0] buffer_n;
    logic [3:0]  count_n;
    logic        pkt_valid_n;
    logic [33:0] pkt_data_n;
    logic        overflow_n;
    logic        flush_pend, flush_pend_n;
    logic        trc_prev;

    logic has_data, full, trc_fall, accept, emit_req, slot_free, drop;

    assign has_data  = (dct_count != 4'd0);
    assign full      = (dct_count == FULL);
    assign trc_fall  = trc_prev & ~trc_on;
    assign accept    = trc_on & dct_valid;
    assign emit_req  = full | (has_data & (flush_pend | flush | trc_fall));
    assign slot_free = ~pkt_valid | pkt_ready;
    assign fsm_state = state;

    always_comb begin
        buffer_n     = dct_buffer;
        count_n      = dct_count;
        pkt_valid_n  = pkt_valid;
        pkt_data_n   = pkt_data;
        flush_pend_n = flush_pend;
        overflow_n   = overflow;
        drop         = 1'b0;
        state_n      = state;

        if (pkt_valid && pkt_ready) begin
            pkt_valid_n = 1'b0;
        end

        if (emit_req && slot_free) begin
            pkt_data_n   = {dct_count, dct_buffer};
            pkt_valid_n  = 1'b1;
            flush_pend_n = 1'b0;
            // A code on the emitting edge seeds the fresh buffer.
            if (accept) begin
                buffer_n = {28'b0, dct_code};
                count_n  = 4'd1;
            end else begin
                buffer_n = 30'b0;
                count_n  = 4'd0;
            end
        end else begin
            // Remember a flush/stop that could not be honoured yet; the
            // buffer keeps collecting until it is full.
            if (emit_req && (flush || trc_fall)) begin
                flush_pend_n = 1'b1;
            end
            if (accept) begin
                if (!full) begin
                    buffer_n = {dct_buffer[27:0], dct_code};
                    count_n  = dct_count + 4'd1;
                end else begin
                    drop = 1'b1;
                end
            end
        end

        // Set wins over clear.
        if (drop) begin
            overflow_n = 1'b1;
        end else if (ovf_clr) begin
            overflow_n = 1'b0;
        end

        // PEND: an emission is owed but the output slot is still occupied.
        if (count_n == 4'd0) begin
            state_n = IDLE;
        end else if ((count_n == FULL || flush_pend_n) && pkt_valid_n) begin
            state_n = PEND;
        end else begin
            state_n = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dct_buffer <= 30'b0;
            dct_count  <= 4'd0;
            pkt_valid  <= 1'b0;
            pkt_data   <= 34'b0;
            overflow   <= 1'b0;
            flush_pend <= 1'b0;
            trc_prev   <= 1'b0;
        end else begin
            state      <= state_n;
            dct_buffer <= buffer_n;
            dct_count  <= count_n;
            pkt_valid  <= pkt_valid_n;
            pkt_data   <= pkt_data_n;
            overflow   <= overflow_n;
            flush_pend <= flush_pend_n;
            trc_prev   <= trc_on;
        end
    end

endmodule

// File: tb/tb_limbus_sys_cpu_oci_dct_packer.sv
// Directed bench for limbus_sys_cpu_oci_dct_packer.
module tb_limbus_sys_cpu_oci_dct_packer;

    logic        clk;
    logic        reset_n;
    logic        trc_on;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        ovf_clr;
    logic        pkt_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        pkt_valid;
    logic [33:0] pkt_data;
    logic        overflow;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COLL = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;

    limbus_sys_cpu_oci_dct_packer #(.FULL_COUNT(15)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trc_on     (trc_on),
        .dct_valid  (dct_valid),
        .dct_code   (dct_code),
        .flush      (flush),
        .ovf_clr    (ovf_clr),
        .pkt_ready  (pkt_ready),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .overflow   (overflow),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input logic [1:0] code);
        for (int i = 0; i < n; i++) begin
            dct_valid = 1'b1;
            dct_code  = code;
            tick();
        end
        dct_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        trc_on    = 1'b0;
        dct_valid = 1'b0;
        dct_code  = 2'b00;
        flush     = 1'b0;
        ovf_clr   = 1'b0;
        pkt_ready = 1'b1;
        tick();
        tick();
        chk("rst_buffer", 34'(dct_buffer), 34'h0);
        chk("rst_count",  34'(dct_count),  34'h0);
        chk("rst_pvalid", 34'(pkt_valid),  34'h0);
        chk("rst_pdata",  pkt_data,        34'h0);
        chk("rst_ovf",    34'(overflow),   34'h0);
        chk("rst_state",  34'(fsm_state),  34'(S_IDLE));
        reset_n = 1'b1;
        tick();

        // Full buffer of 2'b01 with the slot free.
        trc_on = 1'b1;
        fill(14, 2'b01);
        chk("fill_cnt14", 34'(dct_count), 34'd14);
        chk("fill_pv14",  34'(pkt_valid), 34'h0);
        fill(1, 2'b01);
        chk("fill_cnt15", 34'(dct_count),  34'd15);
        chk("fill_buf15", 34'(dct_buffer), 34'h15555555);
        chk("fill_state", 34'(fsm_state),  34'(S_COLL));
        tick();
        chk("fill_pv",    34'(pkt_valid),  34'h1);
        chk("fill_pdata", pkt_data,        {4'hF, 30'h15555555});
        chk("fill_cnt0",  34'(dct_count),  34'h0);
        chk("fill_buf0",  34'(dct_buffer), 34'h0);
        tick();
        chk("fill_drain", 34'(pkt_valid),  34'h0);

        // Partial flush, then a flush on an empty buffer.
        fill(1, 2'b11);
        fill(1, 2'b10);
        fill(1, 2'b01);
        chk("pf_buf", 34'(dct_buffer), 34'h39);
        chk("pf_cnt", 34'(dct_count),  34'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("pf_pv",    34'(pkt_valid), 34'h1);
        chk("pf_pdata", pkt_data,       {4'h3, 30'h39});
        tick();
        chk("pf_drain", 34'(pkt_valid), 34'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ef_pv",  34'(pkt_valid), 34'h0);
        chk("ef_cnt", 34'(dct_count), 34'h0);
        tick();
        chk("ef_pv2", 34'(pkt_valid), 34'h0);

        // Backpressure: held packet, second buffer fills, extra code dropped.
        pkt_ready = 1'b0;
        fill(15, 2'b10);
        tick();
        chk("bp_pv1",    34'(pkt_valid), 34'h1);
        chk("bp_pdata1", pkt_data,       {4'hF, 30'h2AAAAAAA});
        fill(15, 2'b11);
        chk("bp_cnt15",  34'(dct_count),  34'd15);
        chk("bp_buf15",  34'(dct_buffer), 34'h3FFFFFFF);
        chk("bp_state",  34'(fsm_state),  34'(S_PEND));
        chk("bp_ovf0",   34'(overflow),   34'h0);
        fill(1, 2'b01);
        chk("bp_ovf1",   34'(overflow),   34'h1);
        chk("bp_cnt",    34'(dct_count),  34'd15);
        chk("bp_buf",    34'(dct_buffer), 34'h3FFFFFFF);
        chk("bp_hold",   pkt_data,        {4'hF, 30'h2AAAAAAA});
        chk("bp_pvhold", 34'(pkt_valid),  34'h1);
        pkt_ready = 1'b1;
        tick();
        chk("bp_pv2",    34'(pkt_valid), 34'h1);
        chk("bp_pdata2", pkt_data,       {4'hF, 30'h3FFFFFFF});
        chk("bp_cnt0",   34'(dct_count), 34'h0);
        chk("bp_idle",   34'(fsm_state), 34'(S_IDLE));
        tick();
        chk("bp_drain",  34'(pkt_valid), 34'h0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr",   34'(overflow),  34'h0);

        // Code arriving on the emitting edge seeds the new buffer.
        fill(15, 2'b01);
        fill(1, 2'b10);
        chk("sim_pv",    34'(pkt_valid),  34'h1);
        chk("sim_pdata", pkt_data,        {4'hF, 30'h15555555});
        chk("sim_cnt",   34'(dct_count),  34'd1);
        chk("sim_buf",   34'(dct_buffer), 34'h2);
        tick();
        chk("sim_pv0",   34'(pkt_valid),  34'h0);
        chk("sim_keep",  34'(dct_count),  34'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sim_flush", pkt_data,        {4'h1, 30'h2});
        tick();

        // Trace stop emits a partial buffer; codes while off are ignored.
        fill(1, 2'b01);
        fill(1, 2'b10);
        fill(1, 2'b11);
        fill(1, 2'b00);
        fill(1, 2'b01);
        chk("tf_buf", 34'(dct_buffer), 34'h1B1);
        trc_on    = 1'b0;
        dct_valid = 1'b1;
        dct_code  = 2'b11;
        tick();
        chk("tf_pv",    34'(pkt_valid), 34'h1);
        chk("tf_pdata", pkt_data,       {4'h5, 30'h1B1});
        chk("tf_cnt",   34'(dct_count), 34'h0);
        tick();
        dct_valid = 1'b0;
        chk("tf_ign",   34'(dct_count), 34'h0);
        chk("tf_pv0",   34'(pkt_valid), 34'h0);
        chk("tf_ovf",   34'(overflow),  34'h0);

        // Flush while the slot is busy is remembered until the slot frees.
        trc_on    = 1'b1;
        pkt_ready = 1'b0;
        fill(15, 2'b01);
        tick();
        fill(1, 2'b10);
        fill(1, 2'b01);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fp_hold",  pkt_data,        {4'hF, 30'h15555555});
        chk("fp_cnt",   34'(dct_count),  34'd2);
        chk("fp_state", 34'(fsm_state),  34'(S_PEND));
        tick();
        chk("fp_still", 34'(fsm_state),  34'(S_PEND));
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        chk("fp_pdata", pkt_data,        {4'h2, 30'h9});
        chk("fp_pv",    34'(pkt_valid),  34'h1);
        chk("fp_idle",  34'(fsm_state),  34'(S_IDLE));

        // Reset in PEND with overflow set discards everything at once.
        fill(15, 2'b11);
        fill(1, 2'b00);
        chk("rp_state", 34'(fsm_state), 34'(S_PEND));
        chk("rp_ovf",   34'(overflow),  34'h1);
        reset_n = 1'b0;
        #1;
        chk("ar_buffer", 34'(dct_buffer), 34'h0);
        chk("ar_count",  34'(dct_count),  34'h0);
        chk("ar_pvalid", 34'(pkt_valid),  34'h0);
        chk("ar_pdata",  pkt_data,        34'h0);
        chk("ar_ovf",    34'(overflow),   34'h0);
        chk("ar_state",  34'(fsm_state),  34'(S_IDLE));
        tick();
        reset_n = 1'b1;
        fill(1, 2'b11);
        chk("post_cnt", 34'(dct_count),  34'd1);
        chk("post_buf", 34'(dct_buffer), 34'h3);
        chk("post_pv",  34'(pkt_valid),  34'h0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
